// File: rtl/systolic_matmul_nxn.sv
// systolic_matmul_nxn -- N x N output-stationary systolic matrix multiplier.
// Operand vectors enter through skew lines, A flows right, B flows down, and
// every PE accumulates its own C[i][j]. The pipeline only moves on accepted
// input vectors and on drain cycles, so input stalls never corrupt a result.
// Build option: define SYSTOLIC_SAT_EN to make accumulators saturate instead
// of wrapping modulo 2^ACC_WIDTH.
module systolic_matmul_nxn #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         acc_clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      a_vec,
  input  logic [N*DATA_WIDTH-1:0]      b_vec,
  output logic                         busy,
  output logic                         done,
  output logic [N*N*ACC_WIDTH-1:0]     c_out
);

  localparam int CW = $clog2(2*N+1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One MAC update: full signed product, sign-extended, then wrapped or clamped.
  function automatic logic signed [ACC_WIDTH-1:0] mac_step(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
`ifdef SYSTOLIC_SAT_EN
    logic signed [ACC_WIDTH:0]      sum;
`endif
    prod     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    prod_ext = ACC_WIDTH'(prod);
`ifdef SYSTOLIC_SAT_EN
    sum = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      // Overflowed: the extra top bit still carries the true sign.
      if (sum[ACC_WIDTH]) begin
        mac_step = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        mac_step = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      mac_step = sum[ACC_WIDTH-1:0];
    end
`else
    mac_step = acc + prod_ext;
`endif
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] drn_q, drn_d;
  logic          in_ready_q, busy_q, done_q;
  logic          accept_s, en_s, start_s;

  logic signed [DATA_WIDTH-1:0] a_in_s   [N];
  logic signed [DATA_WIDTH-1:0] b_in_s   [N];
  logic signed [DATA_WIDTH-1:0] a_edge_s [N];
  logic signed [DATA_WIDTH-1:0] b_edge_s [N];
  logic signed [DATA_WIDTH-1:0] pe_a_s   [N][N];
  logic signed [DATA_WIDTH-1:0] pe_b_s   [N][N];
  logic signed [DATA_WIDTH-1:0] a_fw_q   [N][N];
  logic signed [DATA_WIDTH-1:0] b_fw_q   [N][N];
  logic signed [ACC_WIDTH-1:0]  acc_q    [N][N];

  assign start_s  = (state_q == ST_IDLE) && start;
  assign accept_s = (state_q == ST_LOAD) && in_valid;
  assign en_s     = accept_s || (state_q == ST_DRAIN);

  // Next-state logic: count accepted vectors, then count the drain cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) begin
            drn_d   = '0;
            state_d = (N == 1) ? ST_DONE : ST_DRAIN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + CW'(1);
        if (drn_q == CW'(2*N-3)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drn_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      in_ready_q <= (state_d == ST_LOAD);
      busy_q     <= (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  genvar gi, gj;

  // Input skew: row/column k is delayed by k enabled cycles; zeros in DRAIN.
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      assign a_in_s[gi] = (state_q == ST_LOAD) ? a_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign b_in_s[gi] = (state_q == ST_LOAD) ? b_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gi == 0) begin : g_nodly
        assign a_edge_s[gi] = a_in_s[gi];
        assign b_edge_s[gi] = b_in_s[gi];
      end else begin : g_dly
        logic signed [DATA_WIDTH-1:0] a_sk_q [gi];
        logic signed [DATA_WIDTH-1:0] b_sk_q [gi];
        // Shift the skew line on enabled cycles; clear on reset and on start.
        always_ff @(posedge clk) begin
          if (rst || start_s) begin
            for (int d = 0; d < gi; d++) begin
              a_sk_q[d] <= '0;
              b_sk_q[d] <= '0;
            end
          end else if (en_s) begin
            a_sk_q[0] <= a_in_s[gi];
            b_sk_q[0] <= b_in_s[gi];
            for (int d = 1; d < gi; d++) begin
              a_sk_q[d] <= a_sk_q[d-1];
              b_sk_q[d] <= b_sk_q[d-1];
            end
          end
        end
        assign a_edge_s[gi] = a_sk_q[gi-1];
        assign b_edge_s[gi] = b_sk_q[gi-1];
      end
    end
  endgenerate

  // PE grid: edge PEs take skewed inputs, inner PEs take the neighbour's copy.
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        if (gj == 0) begin : g_a_edge
          assign pe_a_s[gi][gj] = a_edge_s[gi];
        end else begin : g_a_fwd
          assign pe_a_s[gi][gj] = a_fw_q[gi][gj-1];
        end
        if (gi == 0) begin : g_b_edge
          assign pe_b_s[gi][gj] = b_edge_s[gj];
        end else begin : g_b_fwd
          assign pe_b_s[gi][gj] = b_fw_q[gi-1][gj];
        end

        // Forward operands and accumulate on enabled cycles only.
        always_ff @(posedge clk) begin
          if (rst) begin
            a_fw_q[gi][gj] <= '0;
            b_fw_q[gi][gj] <= '0;
            acc_q[gi][gj]  <= '0;
          end else if (start_s) begin
            a_fw_q[gi][gj] <= '0;
            b_fw_q[gi][gj] <= '0;
            if (acc_clear) begin
              acc_q[gi][gj] <= '0;
            end
          end else if (en_s) begin
            a_fw_q[gi][gj] <= pe_a_s[gi][gj];
            b_fw_q[gi][gj] <= pe_b_s[gi][gj];
            acc_q[gi][gj]  <= mac_step(acc_q[gi][gj], pe_a_s[gi][gj], pe_b_s[gi][gj]);
          end
        end

        assign c_out[(gi*N+gj)*ACC_WIDTH +: ACC_WIDTH] = acc_q[gi][gj];
      end
    end
  endgenerate

endmodule
